// File: rtl/quad_generator.sv
// Quadrature edge generator: steps {quadA,quadB} and a signed position toward
// a target, spacing consecutive edges by a programmable minimum interval.
module quad_generator #(
  parameter int COUNT_BITS = 32,
  parameter int DIV_BITS   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [COUNT_BITS-1:0] target,
  input  logic        [DIV_BITS-1:0]   min_interval,
  input  logic                         load,
  input  logic signed [COUNT_BITS-1:0] preset,
  output logic                         quadA,
  output logic                         quadB,
  output logic signed [COUNT_BITS-1:0] position,
  output logic                         busy,
  output logic                         at_target
);

  logic [1:0]          phase, phase_nxt;
  logic [DIV_BITS-1:0] timer, reload_val;
  logic                issue, dir_up;

  assign {quadA, quadB} = phase;
  assign at_target      = (position == target);

  // Issue decision, direction and next gray-code phase.
  always_comb begin
    issue      = enable && (timer == '0) && !load && !at_target;
    dir_up     = (target > position);
    // An interval of 0 behaves as 1, i.e. the timer reloads with 0.
    reload_val = (min_interval == '0) ? '0 : min_interval - DIV_BITS'(1);
    phase_nxt  = phase;
    if (dir_up) begin
      case (phase)
        2'b00:   phase_nxt = 2'b10;
        2'b10:   phase_nxt = 2'b11;
        2'b11:   phase_nxt = 2'b01;
        default: phase_nxt = 2'b00;
      endcase
    end else begin
      case (phase)
        2'b00:   phase_nxt = 2'b01;
        2'b01:   phase_nxt = 2'b11;
        2'b11:   phase_nxt = 2'b10;
        default: phase_nxt = 2'b00;
      endcase
    end
  end

  // Phase, position, interval timer and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= 2'b00;
      position <= '0;
      timer    <= '0;
      busy     <= 1'b0;
    end else begin
      // Reflects the state seen at this edge, so it trails the timer by one cycle.
      busy <= (timer != '0) || (position != target);
      if (load)
        position <= preset;
      else if (issue)
        position <= dir_up ? position + COUNT_BITS'(1) : position - COUNT_BITS'(1);
      if (issue)
        phase <= phase_nxt;
      // The timer runs down regardless of enable or load; min_interval is
      // only sampled here on reload, so a running interval is never shortened.
      if (issue)
        timer <= reload_val;
      else if (timer != '0)
        timer <= timer - DIV_BITS'(1);
    end
  end

endmodule

// File: tb/tb_quad_generator.sv
// Randomised and directed stimulus for quad_generator with a queue-based
// scoreboard fed by a cycle-count reference model.
module tb_quad_generator;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [31:0] target = '0;
  logic        [15:0] min_interval = '0;
  logic               load = 1'b0;
  logic signed [31:0] preset = '0;
  logic               quadA, quadB, busy, at_target;
  logic signed [31:0] position;

  quad_generator #(.COUNT_BITS(32), .DIV_BITS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .min_interval(min_interval), .load(load), .preset(preset),
    .quadA(quadA), .quadB(quadB), .position(position),
    .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    int         pos;
    logic       busy;
    logic       at;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: edge count mod 4 indexes the up sequence; the interval
  // is tracked as the earliest step index at which another edge is allowed.
  logic [1:0] ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int n = 0;
  int m_pos = 0;
  int m_ph = 0;
  int next_ok = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected post-edge state is queued.
  task automatic step(input bit en, input int tgt, input int mi, input bit ld, input int pre);
    exp_t e;
    bit   tmr_run;
    @(negedge clk);
    reset = 1'b0; enable = en; target = tgt; min_interval = 16'(mi);
    load = ld; preset = pre;
    tmr_run = (n < next_ok);
    e.busy  = tmr_run || (m_pos != tgt);
    if (ld) begin
      m_pos = pre;
    end else if (en && !tmr_run && m_pos != tgt) begin
      if (tgt > m_pos) begin m_pos++; m_ph = (m_ph + 1) % 4; end
      else             begin m_pos--; m_ph = (m_ph + 3) % 4; end
      next_ok = n + ((mi == 0) ? 1 : mi);
    end
    e.ab  = ph_tab[m_ph];
    e.pos = m_pos;
    e.at  = (m_pos == tgt);
    sbq.push_back(e);
    n++;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_A"}, int'(quadA), 0);
    chk({nm, "_B"}, int'(quadB), 0);
    chk({nm, "_pos"}, int'(position), 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    m_pos = 0; m_ph = 0; next_ok = 0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares DUT state just after each edge with the queued model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("phase", int'({quadA, quadB}), int'(e.ab));
        chk("position", int'(position), e.pos);
        chk("busy", int'(busy), int'(e.busy));
        chk("at_target", int'(at_target), int'(e.at));
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);

    // Three up edges, 4-cycle spacing, then busy drains.
    repeat (16) step(1, 3, 4, 0, 0);
    // Back down to 0.
    repeat (16) step(1, 0, 4, 0, 0);
    // One edge per cycle.
    repeat (12) step(1, 10, 0, 0, 0);
    // Enable dropped mid-move, then resumed.
    repeat (5)  step(1, 40, 3, 0, 0);
    repeat (20) step(0, 40, 3, 0, 0);
    repeat (5)  step(1, 40, 3, 0, 0);
    // Load colliding with a pending issue.
    repeat (3)  step(1, 60, 0, 0, 0);
    step(1, 60, 0, 1, -5);
    repeat (6)  step(1, 60, 0, 0, 0);
    // Reversal mid-interval must wait out the timer.
    repeat (3)  step(1, 80, 5, 0, 0);
    repeat (8)  step(1, -20, 5, 0, 0);
    // Reset during a move, then first edge right after release.
    mid_reset();
    repeat (4)  step(1, -30, 2, 0, 0);
    mid_reset();
    repeat (6)  step(1, 7, 1, 0, 0);

    // Randomised traffic.
    begin
      int tgt = 0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) == 0) tgt = int'($urandom_range(0, 40)) - 20;
        step($urandom_range(0, 9) != 0, tgt, int'($urandom_range(0, 5)),
             $urandom_range(0, 29) == 0, int'($urandom_range(0, 40)) - 20);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
